// File: rtl/depth_test_writer.sv
// Depth-test writer: read-compare-write against an on-chip depth buffer, emitting
// frame-buffer writes only for pixels nearer than the stored depth; also owns buffer clear.
module depth_test_writer #(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 180,
    parameter int unsigned DEPTH_WIDTH = 8,
    parameter int unsigned COLOR_WIDTH = 16
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [10:0]                     hcount_in,
    input  logic [9:0]                      vcount_in,
    input  logic [DEPTH_WIDTH-1:0]          depth_in,
    input  logic [COLOR_WIDTH-1:0]          color_in,
    input  logic                            pixel_valid_in,
    input  logic                            clear_in,
    output logic                            ready_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0] fb_addr_out,
    output logic [COLOR_WIDTH-1:0]          fb_color_out,
    output logic                            fb_we_out,
    output logic                            clear_done_out
);

    localparam int unsigned NumPix = WIDTH * HEIGHT;
    localparam int unsigned AddrW  = $clog2(NumPix);
    localparam logic [10:0] WidthLim  = 11'(WIDTH);
    localparam logic [9:0]  HeightLim = 10'(HEIGHT);
    localparam logic [AddrW-1:0] LastAddr = AddrW'(NumPix - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e                 state_q;
    logic                   ready_q;
    logic                   clear_done_q;
    logic [AddrW-1:0]       clr_cnt_q;

    logic                   s0_v_q, s1_v_q, s2_v_q;
    logic [AddrW-1:0]       s0_addr_q, s1_addr_q, s2_addr_q;
    logic [DEPTH_WIDTH-1:0] s0_depth_q, s1_depth_q, s2_depth_q;
    logic [COLOR_WIDTH-1:0] s0_color_q, s1_color_q, s2_color_q;

    logic                   fwd0_v_q, fwd1_v_q;
    logic [AddrW-1:0]       fwd0_addr_q, fwd1_addr_q;
    logic [DEPTH_WIDTH-1:0] fwd0_depth_q, fwd1_depth_q;

    logic                   fb_we_q;
    logic [AddrW-1:0]       fb_addr_q;
    logic [COLOR_WIDTH-1:0] fb_color_q;

    logic [DEPTH_WIDTH-1:0] mem [NumPix];
    logic [DEPTH_WIDTH-1:0] rd1_q, rd2_q;

    logic                   accept;
    logic                   in_range;
    logic [AddrW-1:0]       addr_calc;
    logic [DEPTH_WIDTH-1:0] stored_eff;
    logic                   pass;
    logic                   ram_we;
    logic [AddrW-1:0]       ram_waddr;
    logic [DEPTH_WIDTH-1:0] ram_wdata;

    assign accept    = pixel_valid_in && ready_q;
    assign in_range  = (hcount_in < WidthLim) && (vcount_in < HeightLim);
    assign addr_calc = AddrW'(vcount_in) * AddrW'(WIDTH) + AddrW'(hcount_in);

    // The RAM read misses the two writes retired after it was issued; fwd0 is the younger.
    always_comb begin
        stored_eff = rd2_q;
        if (fwd1_v_q && (fwd1_addr_q == s2_addr_q)) stored_eff = fwd1_depth_q;
        if (fwd0_v_q && (fwd0_addr_q == s2_addr_q)) stored_eff = fwd0_depth_q;
    end

    assign pass = s2_v_q && (s2_depth_q < stored_eff);

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s2_addr_q;
        ram_wdata = s2_depth_q;
        if (state_q == StClear) begin
            ram_we    = !rst_in;
            ram_waddr = clr_cnt_q;
            ram_wdata = '1;
        end else if (pass) begin
            ram_we = !rst_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        rd1_q <= mem[s0_addr_q];
        rd2_q <= rd1_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            ready_q      <= 1'b1;
            clear_done_q <= 1'b0;
            clr_cnt_q    <= '0;
            s0_v_q       <= 1'b0;
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            s0_addr_q    <= '0;
            s1_addr_q    <= '0;
            s2_addr_q    <= '0;
            s0_depth_q   <= '0;
            s1_depth_q   <= '0;
            s2_depth_q   <= '0;
            s0_color_q   <= '0;
            s1_color_q   <= '0;
            s2_color_q   <= '0;
            fwd0_v_q     <= 1'b0;
            fwd1_v_q     <= 1'b0;
            fwd0_addr_q  <= '0;
            fwd1_addr_q  <= '0;
            fwd0_depth_q <= '0;
            fwd1_depth_q <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_color_q   <= '0;
        end else begin
            s0_v_q <= accept && in_range;
            if (accept && in_range) begin
                s0_addr_q  <= addr_calc;
                s0_depth_q <= depth_in;
                s0_color_q <= color_in;
            end
            s1_v_q     <= s0_v_q;
            s1_addr_q  <= s0_addr_q;
            s1_depth_q <= s0_depth_q;
            s1_color_q <= s0_color_q;
            s2_v_q     <= s1_v_q;
            s2_addr_q  <= s1_addr_q;
            s2_depth_q <= s1_depth_q;
            s2_color_q <= s1_color_q;

            fwd1_v_q     <= fwd0_v_q;
            fwd1_addr_q  <= fwd0_addr_q;
            fwd1_depth_q <= fwd0_depth_q;
            fwd0_v_q     <= pass;
            fwd0_addr_q  <= s2_addr_q;
            fwd0_depth_q <= s2_depth_q;

            fb_we_q <= pass;
            if (pass) begin
                fb_addr_q  <= s2_addr_q;
                fb_color_q <= s2_color_q;
            end

            clear_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (clear_in) begin
                        state_q <= StDrain;
                        ready_q <= 1'b0;
                    end
                end
                StDrain: begin
                    if (!s0_v_q && !s1_v_q && !s2_v_q) begin
                        state_q   <= StClear;
                        clr_cnt_q <= '0;
                    end
                end
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LastAddr) begin
                        state_q      <= StIdle;
                        ready_q      <= 1'b1;
                        clear_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_out      = ready_q;
    assign fb_addr_out    = fb_addr_q;
    assign fb_color_out   = fb_color_q;
    assign fb_we_out      = fb_we_q;
    assign clear_done_out = clear_done_q;

endmodule

// File: doc/depth_test_writer.md
Name: depth_test_writer

Overview:
- Sits directly downstream of the rasterizer's painter stage.
- Consumes its per-pixel (hcount, vcount) stream, tagged with the primitive's quantized depth and color.
- Performs a read-compare-write against an internal depth buffer, with nearer = smaller depth.
- Emits frame-buffer write strobes only for pixels that pass the test; also owns depth-buffer clear between frames.

Parameters:
- WIDTH, 320, horizontal resolution in pixels.
- HEIGHT, 180, vertical resolution in pixels.
- DEPTH_WIDTH, 8, bits per stored depth value.
- COLOR_WIDTH, 16, bits per color word passed to the frame buffer.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- hcount_in  input  11  pixel x from painter.
- vcount_in  input  10  pixel y from painter.
- depth_in  input  DEPTH_WIDTH  depth of current primitive.
- color_in  input  COLOR_WIDTH  color of current primitive.
- pixel_valid_in  input  1  pixel present this cycle.
- clear_in  input  1  request depth-buffer clear (single-cycle pulse).
- ready_out  output  1  block accepts pixels this cycle.
- fb_addr_out  output  $clog2(WIDTH*HEIGHT)  frame-buffer address.
- fb_color_out  output  COLOR_WIDTH  frame-buffer write data.
- fb_we_out  output  1  frame-buffer write enable.
- clear_done_out  output  1  one-cycle pulse when clear completes.

Behaviour:
- Reset:
  - All outputs 0, except ready_out = 1.
  - FSM returns to IDLE; pipeline valids cleared.
  - Depth RAM contents are not reset; software/top level issues clear_in after reset.
- Address: addr = vcount_in*WIDTH + hcount_in, computed in stage 0.
- Range check: pixels with hcount_in >= WIDTH or vcount_in >= HEIGHT are dropped in stage 0; no RAM access, no fb write.
- Depth RAM: single instance, WIDTH*HEIGHT x DEPTH_WIDTH, one read port and one write port, 2-cycle registered read latency.
- Pipeline stages:
  - S0: accept pixel, register addr/depth/color.
  - S1: RAM read issued.
  - S2: read data valid.
  - S3: compare and write-back.
- Latency: a pixel sampled with pixel_valid_in && ready_out at edge k produces its fb_* outputs registered at edge k+3. Fully pipelined, one pixel per cycle.
- Depth test: pass iff depth_in < stored (strictly less). Equal depth fails.
- On pass:
  - RAM[addr] <= depth_in.
  - fb_we_out = 1, with fb_addr_out = addr and fb_color_out = color_in.
- On fail: fb_we_out = 0; fb_addr_out and fb_color_out hold their previous values.
- Read-after-write hazard:
  - If a write issued in S3 targets the same address as a pixel in S1 or S2, that pixel's compare uses the forwarded written depth, not the stale RAM data.
  - The youngest matching write wins.
  - Result must equal strict sequential processing.
- FSM:
  - IDLE (ready_out = 1): on clear_in, go to DRAIN.
  - DRAIN (ready_out = 0): wait until S1–S3 are empty, then go to CLEAR with the counter at 0.
  - CLEAR (ready_out = 0): write all-ones depth to RAM[counter] each cycle and increment the counter.
    - After writing address WIDTH*HEIGHT-1, go to IDLE.
    - Pulse clear_done_out for one cycle on the transition.
    - fb_we_out stays 0 throughout CLEAR.
- pixel_valid_in while ready_out = 0 is ignored (not buffered). The upstream painter must stall on ready_out.
- clear_in asserted in the same cycle as an accepted pixel: the pixel is accepted, and the clear starts after it drains.
- clear_in while not in IDLE: ignored.
- Reset mid-clear or mid-pipeline:
  - Abort immediately and go to IDLE.
  - In-flight pixels are discarded; fb_we_out is 0 the cycle after reset.
  - RAM is left partially cleared.

Test Plan:
- Reset, clear_in, wait for clear_done_out. Then pixel (5,3), depth 10, color 0xF800 -> fb_we_out = 1 with fb_addr_out = 965, fb_color_out = 0xF800, exactly 3 cycles after acceptance.
- After the above, send (5,3) with depth 20, then depth 10, then depth 4 on separate cycles -> no write for 20, no write for 10 (tie), write for 4.
- Back-to-back cycles at (7,7), depths 9, 7, 8 on a freshly cleared buffer -> writes for 9 and 7 at addr 2247, no write for 8 (forwarding check).
- Pixels (320,0) and (0,180) -> no fb_we_out, and the RAM entry at addr 0 is unchanged (a later depth 254 at (0,0) still writes).
- clear_in while a pixel is in flight -> the pixel still writes. ready_out stays low for drain + 57600 cycles, then clear_done_out pulses once and ready_out returns high.
- rst_in asserted midway through CLEAR -> next cycle ready_out = 1 and fb_we_out = 0, with no clear_done_out pulse.
